y86_fetch_stage: RTL and testbench

- Parametrised fetch front end for the pipelined Y86 core: PC register, variable-length instruction aligner/splitter, next-PC predictor and an IF/ID pipeline register with stall, flush and redirect control.
- Sits between instruction ROM and decode stage.
- Emits fully split fields (icode, ifun, rA, rB, valC, valP) so decode needs no byte handling.

---
 rtl/y86_fetch_stage.sv | 133 +++++++++++++
 tb/tb_y86_fetch_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/y86_fetch_stage.sv
// y86_fetch_stage: Y86 fetch front end with PC register, instruction aligner/splitter, next-PC predictor and IF/ID register
// Ports:
//   clk, rst (async, active-low)
//   rom_addr_o / rom_data_i : instruction ROM address and the six bytes at that address (byte0 in [47:40])
//   stall_i, flush_i, redirect_i, redirect_pc_i : pipeline control
//   id_* : IF/ID register contents, fields fully split for decode
//   halted_o : fetch stopped after a halt or invalid instruction was passed on
// Build option: define Y86_BRANCH_PREDICT_EN to predict jXX taken (default: not-taken).
module y86_fetch_stage #(
  parameter int                    PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] rom_addr_o,
  input  logic [47:0]         rom_data_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                id_valid,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [3:0]          id_icode,
  output logic [3:0]          id_ifun,
  output logic [3:0]          id_rA,
  output logic [3:0]          id_rB,
  output logic [31:0]         id_valC,
  output logic [PC_WIDTH-1:0] id_valP,
  output logic                id_pred_taken,
  output logic                id_invalid,
  output logic                halted_o
);
  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] pc;
    logic [3:0]          icode;
    logic [3:0]          ifun;
    logic [3:0]          ra;
    logic [3:0]          rb;
    logic [31:0]         valc;
    logic [PC_WIDTH-1:0] valp;
    logic                pred;
    logic                invalid;
  } ifid_t;

  logic [PC_WIDTH-1:0] pc_q, pc_d, next_pc;
  logic                halted_q, halted_d;
  ifid_t               id_q, id_d, fetched, bubble;
  logic [3:0]          icode;
  logic [2:0]          len;
  logic                has_regs, taken, invalid;
  logic [31:0]         valc;

  always_comb begin
    icode    = rom_data_i[47:44];
    invalid  = icode > 4'hB;
    len      = (icode inside {4'h7, 4'h8})       ? 3'd5 :
               (icode inside {4'h3, 4'h4, 4'h5}) ? 3'd6 :
               (icode inside {4'h2, 4'h6, 4'hA, 4'hB}) ? 3'd2 : 3'd1;
    has_regs = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    // valC is little-endian: the lowest-addressed constant byte is the LSB
    valc     = (icode inside {4'h7, 4'h8})       ? {rom_data_i[15:8], rom_data_i[23:16], rom_data_i[31:24], rom_data_i[39:32]} :
               (icode inside {4'h3, 4'h4, 4'h5}) ? {rom_data_i[7:0], rom_data_i[15:8], rom_data_i[23:16], rom_data_i[31:24]} : '0;
`ifdef Y86_BRANCH_PREDICT_EN
    taken    = icode == 4'h8 || icode == 4'h7;
`else
    taken    = icode == 4'h8;
`endif
    fetched.valid   = 1'b1;
    fetched.pc      = pc_q;
    fetched.icode   = icode;
    fetched.ifun    = rom_data_i[43:40];
    fetched.ra      = has_regs ? rom_data_i[39:36] : 4'hF;
    fetched.rb      = has_regs ? rom_data_i[35:32] : 4'hF;
    fetched.valc    = valc;
    fetched.valp    = pc_q + PC_WIDTH'(len);
    fetched.pred    = taken;
    fetched.invalid = invalid;
    next_pc         = taken ? PC_WIDTH'(valc) : fetched.valp;
    bubble       = '0;
    bubble.icode = 4'h1;
    bubble.ra    = 4'hF;
    bubble.rb    = 4'hF;
  end

  // redirect > stall > flush > halted > normal; a flushed slot never sets halted
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    id_d     = id_q;
    if (redirect_i) begin
      pc_d     = redirect_pc_i;
      halted_d = 1'b0;
      id_d     = bubble;
    end else if (!stall_i) begin
      if (flush_i) begin
        id_d = bubble;
        pc_d = next_pc;
      end else if (halted_q) begin
        id_d = bubble;
      end else begin
        id_d     = fetched;
        pc_d     = next_pc;
        halted_d = icode == 4'h0 || invalid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      id_q     <= bubble;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      id_q     <= id_d;
    end
  end

  assign rom_addr_o    = pc_q;
  assign halted_o      = halted_q;
  assign id_valid      = id_q.valid;
  assign id_pc         = id_q.pc;
  assign id_icode      = id_q.icode;
  assign id_ifun       = id_q.ifun;
  assign id_rA         = id_q.ra;
  assign id_rB         = id_q.rb;
  assign id_valC       = id_q.valc;
  assign id_valP       = id_q.valp;
  assign id_pred_taken = id_q.pred;
  assign id_invalid    = id_q.invalid;
endmodule

// File: tb/tb_y86_fetch_stage.sv
// tb_y86_fetch_stage: directed self-checking bench for y86_fetch_stage (32-bit instance plus an 8-bit wrap instance)
module tb_y86_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_addr;
  logic [47:0] rom_data;
  logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid, id_pred_taken, id_invalid, halted;
  logic [31:0] id_pc, id_valC, id_valP;
  logic [3:0]  id_icode, id_ifun, id_rA, id_rB;
  logic [7:0]  rom_addr8, id_pc8, id_valP8;
  logic        id_valid8, id_pred8, id_invalid8, halted8;
  logic [3:0]  id_icode8, id_ifun8, id_rA8, id_rB8;
  logic [31:0] id_valC8;
  logic [7:0]  mem [0:511];
  logic [8:0]  a;
  logic [31:0] exp_pc;
  logic        exp_pred;
  int          n_chk = 0, n_bad = 0;

  always #5 clk = ~clk;

  y86_fetch_stage u_dut (
    .clk(clk), .rst(rst), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .stall_i(stall), .flush_i(flush), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_icode(id_icode), .id_ifun(id_ifun),
    .id_rA(id_rA), .id_rB(id_rB), .id_valC(id_valC), .id_valP(id_valP),
    .id_pred_taken(id_pred_taken), .id_invalid(id_invalid), .halted_o(halted)
  );

  y86_fetch_stage #(.PC_WIDTH(8), .RESET_PC(8'hFE)) u_dut8 (
    .clk(clk), .rst(rst), .rom_addr_o(rom_addr8), .rom_data_i(48'h30F0_0400_0000),
    .stall_i(1'b0), .flush_i(1'b0), .redirect_i(1'b0), .redirect_pc_i(8'h00),
    .id_valid(id_valid8), .id_pc(id_pc8), .id_icode(id_icode8), .id_ifun(id_ifun8),
    .id_rA(id_rA8), .id_rB(id_rB8), .id_valC(id_valC8), .id_valP(id_valP8),
    .id_pred_taken(id_pred8), .id_invalid(id_invalid8), .halted_o(halted8)
  );

  always_comb begin
    a        = rom_addr[8:0];
    rom_data = {mem[a], mem[a + 9'd1], mem[a + 9'd2], mem[a + 9'd3], mem[a + 9'd4], mem[a + 9'd5]};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h10;
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = 48'h30F2_0400_0000;
    mem[6] = 8'h10;
    {mem[7], mem[8]} = 16'h6012;
    mem[9] = 8'h00;
    {mem['h10], mem['h11], mem['h12], mem['h13], mem['h14]} = 40'h74_0001_0000;
    mem['h20] = 8'hC0;
    {mem['h30], mem['h31], mem['h32], mem['h33], mem['h34]} = 40'h80_0002_0000;
    #1 rst = 1'b0;
    #2;
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_icode", 64'(id_icode), 64'h1);
    check("rst_rA", 64'(id_rA), 64'hF);
    check("rst_rB", 64'(id_rB), 64'hF);
    check("rst_addr", 64'(rom_addr), 64'h0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_valC", 64'(id_valC), 64'd0);
    check("rst_addr8", 64'(rom_addr8), 64'hFE);
    step();
    step();
    rst = 1'b1;
    // irmovl $4,%edx at 0
    step();
    check("irm_valid", 64'(id_valid), 64'd1);
    check("irm_icode", 64'(id_icode), 64'h3);
    check("irm_rA", 64'(id_rA), 64'hF);
    check("irm_rB", 64'(id_rB), 64'h2);
    check("irm_valC", 64'(id_valC), 64'd4);
    check("irm_valP", 64'(id_valP), 64'd6);
    check("irm_addr", 64'(rom_addr), 64'd6);
    check("wrap_valP8", 64'(id_valP8), 64'h04);
    check("wrap_pc8", 64'(id_pc8), 64'hFE);
    check("wrap_addr8", 64'(rom_addr8), 64'h04);
    // nop at 6
    step();
    check("nop_icode", 64'(id_icode), 64'h1);
    check("nop_valP", 64'(id_valP), 64'd7);
    check("nop_rA", 64'(id_rA), 64'hF);
    // addl %ecx,%edx at 7
    step();
    check("add_icode", 64'(id_icode), 64'h6);
    check("add_rA", 64'(id_rA), 64'h1);
    check("add_rB", 64'(id_rB), 64'h2);
    check("add_valP", 64'(id_valP), 64'd9);
    check("add_pc", 64'(id_pc), 64'd7);
    stall = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", 64'(rom_addr), 64'd9);
      check("stall_icode", 64'(id_icode), 64'h6);
      check("stall_valP", 64'(id_valP), 64'd9);
      check("stall_valid", 64'(id_valid), 64'd1);
    end
    stall = 1'b0;
    flush = 1'b0;
    // halt at 9
    step();
    check("halt_icode", 64'(id_icode), 64'h0);
    check("halt_valid", 64'(id_valid), 64'd1);
    check("halt_valP", 64'(id_valP), 64'hA);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_addr", 64'(rom_addr), 64'hA);
    for (int i = 0; i < 2; i++) begin
      step();
      check("halted_valid", 64'(id_valid), 64'd0);
      check("halted_addr", 64'(rom_addr), 64'hA);
      check("halted_flag", 64'(halted), 64'd1);
    end
    // redirect beats stall and clears halt
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    check("redir_addr", 64'(rom_addr), 64'h40);
    check("redir_halted", 64'(halted), 64'd0);
    check("redir_valid", 64'(id_valid), 64'd0);
    stall = 1'b0;
    redirect = 1'b0;
    step();
    check("resume_valid", 64'(id_valid), 64'd1);
    check("resume_valP", 64'(id_valP), 64'h41);
    // jne at 0x10
    redirect = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    step();
`ifdef Y86_BRANCH_PREDICT_EN
    exp_pc = 32'h100;
    exp_pred = 1'b1;
`else
    exp_pc = 32'h15;
    exp_pred = 1'b0;
`endif
    check("jne_icode", 64'(id_icode), 64'h7);
    check("jne_ifun", 64'(id_ifun), 64'h4);
    check("jne_valC", 64'(id_valC), 64'h100);
    check("jne_valP", 64'(id_valP), 64'h15);
    check("jne_pred", 64'(id_pred_taken), 64'(exp_pred));
    check("jne_addr", 64'(rom_addr), 64'(exp_pc));
    // flush: bubble, PC still advances past the nop there
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 64'(id_valid), 64'd0);
    check("flush_icode", 64'(id_icode), 64'h1);
    check("flush_addr", 64'(rom_addr), 64'(exp_pc + 32'd1));
    // call at 0x30 is always taken
    redirect = 1'b1;
    redirect_pc = 32'h30;
    step();
    redirect = 1'b0;
    step();
    check("call_valC", 64'(id_valC), 64'h200);
    check("call_valP", 64'(id_valP), 64'h35);
    check("call_pred", 64'(id_pred_taken), 64'd1);
    check("call_addr", 64'(rom_addr), 64'h200);
    // invalid opcode at 0x20
    redirect = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    step();
    check("inv_invalid", 64'(id_invalid), 64'd1);
    check("inv_valid", 64'(id_valid), 64'd1);
    check("inv_valP", 64'(id_valP), 64'h21);
    check("inv_halted", 64'(halted), 64'd1);
    check("inv_rA", 64'(id_rA), 64'hF);
    // asynchronous reset while halted and stalled
    stall = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("arst_halted", 64'(halted), 64'd0);
    check("arst_addr", 64'(rom_addr), 64'h0);
    check("arst_valid", 64'(id_valid), 64'd0);
    check("arst_invalid", 64'(id_invalid), 64'd0);
    stall = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("rerun_icode", 64'(id_icode), 64'h3);
    check("rerun_addr", 64'(rom_addr), 64'd6);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
